// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared word layout, widths and FSM states for the DAC frame writer
package dac_pkg;

  localparam int DATA_W   = 12;
  localparam int WORD_W   = 16;
  localparam int CH_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP_A,
    SHIFT_B,
    GAP_B,
    LATCH
  } dac_state_t;

  // Builds one MCP4922-style command word; SHDN_n is always 1 (output active).
  function automatic logic [WORD_W-1:0] make_word(
    input logic              ch,
    input logic              buf_en,
    input logic              gain_1x,
    input logic [DATA_W-1:0] code
  );
    logic [WORD_W-1:0] w;
    w              = '0;
    w[DATA_W-1:0]  = code;
    w[SHDN_BIT]    = 1'b1;
    w[GA_BIT]      = gain_1x;
    w[BUF_BIT]     = buf_en;
    w[CH_BIT]      = ch;
    return w;
  endfunction

endpackage

// File: rtl/dac_word_shift.sv
// rtl/dac_word_shift.sv - 16-bit MSB-first SPI word shifter with SCLK divider
module dac_word_shift
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              busy,
  output logic              clk_pin,
  output logic              data_pin
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [WORD_W-1:0] r_sr;
  logic [DIV_W-1:0]  r_div;
  logic [4:0]        r_edge;
  logic              r_busy;
  logic              r_sclk;
  logic              r_data;

  // Load puts the MSB on SDI immediately; SDI then only moves on SCLK falling
  // edges. The 32nd toggle is a falling edge that ends the word with SCLK low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr   <= '0;
      r_div  <= '0;
      r_edge <= '0;
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_data <= 1'b0;
    end else if (start) begin
      r_sr   <= {word[WORD_W-2:0], 1'b0};
      r_data <= word[WORD_W-1];
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= 1'b0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
        if (r_sclk) begin
          r_data <= r_sr[WORD_W-1];
          r_sr   <= {r_sr[WORD_W-2:0], 1'b0};
        end
        if (r_edge == 5'd31) begin
          r_busy <= 1'b0;
          r_data <= 1'b0;
        end else begin
          r_edge <= r_edge + 5'd1;
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign busy     = r_busy;
  assign clk_pin  = r_sclk;
  assign data_pin = r_data;

endmodule

// File: rtl/dac_frame_writer.sv
// rtl/dac_frame_writer.sv - writes one (x, y) sample to a dual-channel SPI DAC then pulses LDAC
module dac_frame_writer
  import dac_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2,
  parameter int LDAC_WIDTH = 2,
  parameter bit BUF_EN     = 1'b0,
  parameter bit GAIN_1X    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              valid,
  output logic              ready,
  output logic              cs_pin,
  output logic              clk_pin,
  output logic              data_pin,
  output logic              ldac_pin
);

  localparam int SHIFT_CYC = 32 * CLK_DIV;
  localparam int MAX_SG    = (SHIFT_CYC > CS_GAP) ? SHIFT_CYC : CS_GAP;
  localparam int MAX_CYC   = (MAX_SG > LDAC_WIDTH) ? MAX_SG : LDAC_WIDTH;
  localparam int CNT_W     = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(SHIFT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LOAD  = CNT_W'(LDAC_WIDTH - 1);

  dac_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_y;
  logic              r_ready;
  logic              r_ldac;

  logic              w_start;
  logic [WORD_W-1:0] w_word;
  logic              w_busy;

  // Word A loads straight from x on the accept edge; word B from the y latched then.
  assign w_start = ((r_state == IDLE) && valid) || ((r_state == GAP_A) && (r_cnt == '0));
  assign w_word  = (r_state == IDLE) ? make_word(1'b0, BUF_EN, GAIN_1X, x)
                                     : make_word(1'b1, BUF_EN, GAIN_1X, r_y);

  dac_word_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .word     (w_word),
    .busy     (w_busy),
    .clk_pin  (clk_pin),
    .data_pin (data_pin)
  );

  // Frame sequencing: each state lasts a fixed count so the shifter and FSM stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_ready <= 1'b1;
      r_ldac  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_state <= SHIFT_A;
            r_cnt   <= SHIFT_LOAD;
            r_y     <= y;
            r_ready <= 1'b0;
          end
        end
        SHIFT_A: begin
          if (r_cnt == '0) begin
            r_state <= GAP_A;
            r_cnt   <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP_A: begin
          if (r_cnt == '0) begin
            r_state <= SHIFT_B;
            r_cnt   <= SHIFT_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        SHIFT_B: begin
          if (r_cnt == '0) begin
            r_state <= GAP_B;
            r_cnt   <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP_B: begin
          if (r_cnt == '0) begin
            r_state <= LATCH;
            r_cnt   <= LDAC_LOAD;
            r_ldac  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        LATCH: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_ldac  <= 1'b1;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ldac  <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // The shifter's busy flop spans exactly the chip-select window of each word.
  assign cs_pin   = ~w_busy;
  assign ready    = r_ready;
  assign ldac_pin = r_ldac;

endmodule

// File: tb/tb_dac_frame_writer.sv
// tb/tb_dac_frame_writer.sv - directed self-checking bench for dac_frame_writer
module tb_dac_frame_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] x[2];
  logic [11:0] y[2];
  logic        valid[2];
  logic        ready[2];
  logic        cs[2];
  logic        sclk[2];
  logic        sdata[2];
  logic        ldac[2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  logic [15:0] words[2][16];
  int          csf[2][16];
  int          csr[2][16];
  int          ldst[2][8];
  int          ldlen[2][8];
  int          rdy[2][8];
  int          nw[2], ncf[2], ncr[2], nld[2], nrdy[2], npart[2];
  logic [15:0] sh[2];
  int          nbits[2];
  logic        pcs[2]   = '{1'b1, 1'b1};
  logic        psclk[2] = '{1'b0, 1'b0};
  logic        pdata[2] = '{1'b0, 1'b0};
  logic        pldac[2] = '{1'b1, 1'b1};
  logic        prdy[2]  = '{1'b1, 1'b1};

  dac_frame_writer u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .x        (x[0]),
    .y        (y[0]),
    .valid    (valid[0]),
    .ready    (ready[0]),
    .cs_pin   (cs[0]),
    .clk_pin  (sclk[0]),
    .data_pin (sdata[0]),
    .ldac_pin (ldac[0])
  );

  dac_frame_writer #(
    .CLK_DIV    (1),
    .CS_GAP     (1),
    .LDAC_WIDTH (1)
  ) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .x        (x[1]),
    .y        (y[1]),
    .valid    (valid[1]),
    .ready    (ready[1]),
    .cs_pin   (cs[1]),
    .clk_pin  (sclk[1]),
    .data_pin (sdata[1]),
    .ldac_pin (ldac[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI monitor: decodes words on SCLK rising edges and timestamps pin events.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!cs[i] && pcs[i]) begin
        if (ncf[i] < 16) csf[i][ncf[i]] = cyc;
        ncf[i]++;
        nbits[i] = 0;
        sh[i] = '0;
      end
      if (cs[i] && !pcs[i]) begin
        if (ncr[i] < 16) csr[i][ncr[i]] = cyc;
        ncr[i]++;
        if (nbits[i] == 16) begin
          if (nw[i] < 16) words[i][nw[i]] = sh[i];
          nw[i]++;
        end else begin
          npart[i]++;
        end
      end
      if (!cs[i] && sclk[i] && !psclk[i]) begin
        sh[i] = {sh[i][14:0], sdata[i]};
        nbits[i]++;
        chk("data_stable_at_rise", sdata[i], pdata[i]);
      end
      if (cs[i]) chk("idle_pins_low", {sclk[i], sdata[i]}, 2'b00);
      if (!ldac[i] && pldac[i]) begin
        if (nld[i] < 8) begin
          ldst[i][nld[i]] = cyc;
          ldlen[i][nld[i]] = 0;
        end
        nld[i]++;
      end
      if (!ldac[i]) begin
        if (nld[i] > 0 && nld[i] <= 8) ldlen[i][nld[i]-1]++;
        chk("cs_high_during_ldac", cs[i], 1'b1);
      end
      if (ready[i] && !prdy[i]) begin
        if (nrdy[i] < 8) rdy[i][nrdy[i]] = cyc;
        nrdy[i]++;
      end
      pcs[i]   = cs[i];
      psclk[i] = sclk[i];
      pdata[i] = sdata[i];
      pldac[i] = ldac[i];
      prdy[i]  = ready[i];
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      nw[i] = 0; ncf[i] = 0; ncr[i] = 0; nld[i] = 0; nrdy[i] = 0; npart[i] = 0;
    end
  endtask

  task automatic send(input int i, input logic [11:0] xv, input logic [11:0] yv);
    x[i] = xv;
    y[i] = yv;
    valid[i] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic wait_rdy(input int i, input int n);
    int b;
    b = 0;
    while (nrdy[i] < n && b < 400) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("ready_wait_bound", nrdy[i] >= n, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      x[i] = '0; y[i] = '0; valid[i] = 1'b0;
      nbits[i] = 0; sh[i] = '0;
    end
    clear_mon();

    // Reset values
    step(3);
    chk("rst_ready", ready[0], 1'b1);
    chk("rst_cs", cs[0], 1'b1);
    chk("rst_sclk", sclk[0], 1'b0);
    chk("rst_data", sdata[0], 1'b0);
    chk("rst_ldac", ldac[0], 1'b1);
    chk("rst_ready1", ready[1], 1'b1);
    reset = 1'b0;
    step(2);

    // Single sample, default timing
    clear_mon();
    send(0, 12'hABC, 12'h123);
    chk("s1_ready_drop", ready[0], 1'b0);
    wait_rdy(0, 1);
    chk("s1_nwords", nw[0], 2);
    chk("s1_word_a", words[0][0], 16'h3ABC);
    chk("s1_word_b", words[0][1], 16'hB123);
    chk("s1_csfall_a", csf[0][0] - t0 + 1, 1);
    chk("s1_csrise_a", csr[0][0] - t0 + 1, 65);
    chk("s1_csfall_b", csf[0][1] - t0 + 1, 67);
    chk("s1_csrise_b", csr[0][1] - t0 + 1, 131);
    chk("s1_ldac_start", ldst[0][0] - t0 + 1, 133);
    chk("s1_ldac_len", ldlen[0][0], 2);
    chk("s1_nldac", nld[0], 1);
    chk("s1_ready_at", rdy[0][0] - t0 + 1, 135);

    // Back-to-back with valid held high, boundary codes
    step(3);
    clear_mon();
    x[0] = 12'h000; y[0] = 12'h000; valid[0] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    #1;
    x[0] = 12'hFFF; y[0] = 12'hFFF;
    wait_rdy(0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    valid[0] = 1'b0;
    wait_rdy(0, 2);
    chk("b2b_nwords", nw[0], 4);
    chk("b2b_w0", words[0][0], 16'h3000);
    chk("b2b_w1", words[0][1], 16'hB000);
    chk("b2b_w2", words[0][2], 16'h3FFF);
    chk("b2b_w3", words[0][3], 16'hBFFF);
    chk("b2b_second_csfall", csf[0][2] - t0 + 1, 136);
    chk("b2b_nldac", nld[0], 2);

    // Input changes and a dropped valid pulse while busy
    step(3);
    clear_mon();
    send(0, 12'h0F0, 12'hA5A);
    step(9);
    x[0] = 12'h555; y[0] = 12'h555;
    step(10);
    valid[0] = 1'b1;
    step(1);
    valid[0] = 1'b0;
    wait_rdy(0, 1);
    step(20);
    chk("busy_nwords", nw[0], 2);
    chk("busy_word_a", words[0][0], 16'h30F0);
    chk("busy_word_b", words[0][1], 16'hBA5A);
    chk("busy_nldac", nld[0], 1);
    chk("busy_ncsfall", ncf[0], 2);

    // Reset mid-frame aborts without an LDAC pulse
    clear_mon();
    send(0, 12'h321, 12'h654);
    step(39);
    chk("abort_pre_cs", cs[0], 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_cs", cs[0], 1'b1);
    chk("abort_sclk", sclk[0], 1'b0);
    chk("abort_data", sdata[0], 1'b0);
    chk("abort_ldac", ldac[0], 1'b1);
    chk("abort_ready", ready[0], 1'b1);
    step(2);
    reset = 1'b0;
    step(150);
    chk("abort_nldac", nld[0], 0);
    chk("abort_nwords", nw[0], 0);
    chk("abort_partial", npart[0], 1);
    clear_mon();
    send(0, 12'h7FE, 12'h801);
    wait_rdy(0, 1);
    chk("post_nwords", nw[0], 2);
    chk("post_word_a", words[0][0], 16'h37FE);
    chk("post_word_b", words[0][1], 16'hB801);
    chk("post_nldac", nld[0], 1);

    // Minimum divider, gap and latch widths
    step(3);
    clear_mon();
    send(1, 12'h9C3, 12'h36A);
    wait_rdy(1, 1);
    chk("fast_nwords", nw[1], 2);
    chk("fast_word_a", words[1][0], 16'h39C3);
    chk("fast_word_b", words[1][1], 16'hB36A);
    chk("fast_csfall_a", csf[1][0] - t0 + 1, 1);
    chk("fast_cs_low_len", csr[1][0] - csf[1][0], 32);
    chk("fast_csfall_b", csf[1][1] - t0 + 1, 34);
    chk("fast_ldac_start", ldst[1][0] - t0 + 1, 67);
    chk("fast_ldac_len", ldlen[1][0], 1);
    chk("fast_ready_at", rdy[1][0] - t0 + 1, 68);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_frame_writer.md
Name: dac_frame_writer

Overview:
- Downstream output stage of the line-draw `control` block.
- Takes one 12-bit (x, y) sample per handshake and writes it to a dual-channel 12-bit SPI DAC (MCP4922-style): x to channel A, then y to channel B.
- After both words, pulses LDAC so both analog outputs update on the same edge. This prevents X/Y skew on the vector beam.
- Replaces the inline serializer currently driving cs/dclk/data.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period. Must be ≥1.
- CS_GAP, 2: clk cycles cs_pin is held high after each word. Must be ≥1.
- LDAC_WIDTH, 2: clk cycles ldac_pin is held low. Must be ≥1.
- BUF_EN, 0: value of the DAC VREF buffer bit (bit 14).
- GAIN_1X, 1: value of the GA_n bit (bit 13). 1 selects 1x gain.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  12  channel A code.
- y  in  12  channel B code.
- valid  in  1  sample request.
- ready  out  1  idle, able to accept a sample.
- cs_pin  out  1  DAC chip select, active low.
- clk_pin  out  1  SCLK; idles low.
- data_pin  out  1  SDI, MSB first.
- ldac_pin  out  1  DAC latch, active low.

Behaviour:
- Reset values (asynchronous, active-high): ready=1, cs_pin=1, clk_pin=0, data_pin=0, ldac_pin=1, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial LDAC pulse is issued.
- Handshake and input capture:
  - A sample is accepted on a rising edge where valid && ready. ready drops the next cycle.
  - x and y are registered at acceptance. Input changes while busy are ignored.
  - valid while !ready is dropped, not queued.
- Word format, 16 bits: {ch, BUF_EN, GAIN_1X, 1'b1 (SHDN_n), code[11:0]}. ch=0 for x, ch=1 for y.
- FSM states: IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LATCH.
  - IDLE→SHIFT_A on accept.
  - SHIFT_A→GAP_A after 32*CLK_DIV cycles.
  - GAP_A→SHIFT_B after CS_GAP cycles.
  - SHIFT_B→GAP_B after 32*CLK_DIV cycles.
  - GAP_B→LATCH after CS_GAP cycles.
  - LATCH→IDLE after LDAC_WIDTH cycles.
- SHIFT timing:
  - cs_pin falls on the first SHIFT cycle, with data_pin already holding the MSB.
  - clk_pin toggles every CLK_DIV cycles, starting low: 16 rising edges per word.
  - data_pin changes only on clk_pin falling edges, so it is stable across each rising edge (the DAC samples on rising).
  - At the end of a word, clk_pin is low and cs_pin returns high on the same cycle.
- Gap states: cs_pin=1, clk_pin=0, data_pin=0.
- LATCH: ldac_pin=0 for exactly LDAC_WIDTH cycles, while cs_pin=1.
- Latency with defaults, accept edge = cycle T:
  - cs_pin low T+1..T+64 (word A).
  - cs_pin high T+65..T+66.
  - cs_pin low T+67..T+130 (word B).
  - cs_pin high T+131..T+132.
  - ldac_pin low T+133..T+134.
  - ready=1 from T+135.
- General throughput: one sample per 64*CLK_DIV + 2*CS_GAP + LDAC_WIDTH + 1 cycles.
- Back-to-back: valid held high is accepted on the first ready cycle (T+135). The next cs_pin fall is at T+136.
- Boundary codes: 12'h000 and 12'hFFF are shifted unmodified. There is no saturation or sign handling.
- Counters: the divider counter width is $clog2(CLK_DIV)+1. The bit counter is 5 bits (edge count 0..31) and does not wrap beyond one word.

Decomposition:
- Shared package (dac_pkg): word bit positions (CH_BIT=15, BUF_BIT=14, GA_BIT=13, SHDN_BIT=12), DATA_W=12, WORD_W=16, FSM state enum.
- One sub-module: dac_word_shift.
  - Function: 16-bit load/shift register plus SCLK divider.
  - Ports: start, word[15:0], busy, clk_pin, data_pin.
  - dac_frame_writer owns the FSM, cs_pin, ldac_pin, gaps and handshake.

Test Plan:
- x=12'hABC, y=12'h123, single accept at T → bench SPI monitor decodes word A = 16'h3ABC and word B = 16'hB123 (with BUF_EN=0, GAIN_1X=1); ldac_pin low T+133..T+134; ready at T+135.
- valid held high, samples (0,0) then (FFF,FFF) → second cs_pin fall at T+136; words 16'h3000, 16'hB000, 16'h3FFF, 16'hBFFF in order.
- x/y changed to 12'h555 at T+10 during SHIFT_A → transmitted codes still equal the values latched at T.
- valid pulsed at T+20 while busy → ignored; exactly two words and one LDAC pulse occur per accepted sample.
- reset asserted at T+40 → same-cycle cs_pin=1, clk_pin=0, data_pin=0, ldac_pin=1, ready=1; no LDAC pulse; the next sample after release is transmitted correctly.
- CLK_DIV=1, CS_GAP=1, LDAC_WIDTH=1 → cs_pin low 32 cycles per word; ready returns at T+68; data_pin stable at every clk_pin rising edge (checked by assertion).
